// File: rtl/regfile_mp.sv
// regfile_mp: multi-port 16-bit register-pair file for the CPU datapath.
//
// Holds NUM_PAIRS 16-bit pairs (default 0 BC, 1 DE, 2 HL, 3 SP, 4 PC). A and F live elsewhere.
// All updates land on the same clock edge; same-pair conflicts resolve as
// write port > IDU > PC stepper, with the loser dropped entirely.
//
// Select encoding for rsel_a / rsel_b / wsel: {full, hi, idx[IDX_W-1:0]}.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   rsel_a, rdata_a     read port A (combinational; byte reads zero-extended)
//   rsel_b, rdata_b     read port B, same rules
//   we, wsel, wdata     byte/word write port (byte writes use wdata[7:0])
//   idu_en/idx/dec      increment/decrement unit, pair[idu_idx] +/- 1
//   pc_change, pc_inc   PC stepper on pair PC_IDX
//   pc_out, sp_out      stored PC and SP (never bypassed)
//   oob_err             sticky flag: an enabled access used idx >= NUM_PAIRS
//
// Configuration macro: REGFILE_BYPASS_EN -- when defined, read ports forward the write port's
// result in the same cycle (IDU/PC results are never forwarded).

module regfile_mp #(
  parameter int unsigned NUM_PAIRS = 5,
  parameter int unsigned PC_IDX    = 4,
  parameter int unsigned SP_IDX    = 3,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] RESET_SP  = 16'h0000,
  parameter int unsigned IDX_W     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W+1:0] rsel_a,
  input  logic [IDX_W+1:0] rsel_b,
  output logic [15:0]      rdata_a,
  output logic [15:0]      rdata_b,
  input  logic             we,
  input  logic [IDX_W+1:0] wsel,
  input  logic [15:0]      wdata,
  input  logic             idu_en,
  input  logic [IDX_W-1:0] idu_idx,
  input  logic             idu_dec,
  input  logic             pc_change,
  input  logic             pc_inc,
  output logic [15:0]      pc_out,
  output logic [15:0]      sp_out,
  output logic             oob_err
);

  typedef logic [NUM_PAIRS-1:0][15:0] file_t;

  function automatic file_t reset_file();
    file_t f;
    for (int i = 0; i < int'(NUM_PAIRS); i++) begin
      if (i == int'(PC_IDX)) begin
        f[i] = RESET_PC;
      end else if (i == int'(SP_IDX)) begin
        f[i] = RESET_SP;
      end else begin
        f[i] = 16'h0000;
      end
    end
    return f;
  endfunction

  // Out-of-range idx reads back as zero.
  function automatic logic [15:0] read_port(input file_t f, input logic [IDX_W+1:0] sel);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < int'(NUM_PAIRS); i++) begin
      if (sel[IDX_W-1:0] == IDX_W'(i)) begin
        if (sel[IDX_W+1]) begin
          r = f[i];
        end else if (sel[IDX_W]) begin
          r = {8'h00, f[i][15:8]};
        end else begin
          r = {8'h00, f[i][7:0]};
        end
      end
    end
    return r;
  endfunction

  file_t pairs_q, pairs_d;
  file_t wr_view;  // registered state with only the write port applied
  file_t rd_view;
  logic  oob_q, oob_d;

  logic oob_ra, oob_rb, oob_w, oob_idu;

  assign oob_ra  = 32'(rsel_a[IDX_W-1:0]) >= NUM_PAIRS;
  assign oob_rb  = 32'(rsel_b[IDX_W-1:0]) >= NUM_PAIRS;
  assign oob_w   = 32'(wsel[IDX_W-1:0]) >= NUM_PAIRS;
  assign oob_idu = 32'(idu_idx) >= NUM_PAIRS;

  always_comb begin
    wr_view = pairs_q;
    pairs_d = pairs_q;
    for (int i = 0; i < int'(NUM_PAIRS); i++) begin
      if (we && (wsel[IDX_W-1:0] == IDX_W'(i))) begin
        if (wsel[IDX_W+1]) begin
          wr_view[i] = wdata;
        end else if (wsel[IDX_W]) begin
          wr_view[i] = {wdata[7:0], pairs_q[i][7:0]};
        end else begin
          wr_view[i] = {pairs_q[i][15:8], wdata[7:0]};
        end
        pairs_d[i] = wr_view[i];
      end else if (idu_en && (idu_idx == IDX_W'(i))) begin
        pairs_d[i] = idu_dec ? pairs_q[i] - 16'd1 : pairs_q[i] + 16'd1;
      end else if (pc_change && (i == int'(PC_IDX))) begin
        pairs_d[i] = pc_inc ? pairs_q[i] + 16'd1 : pairs_q[i] - 16'd1;
      end
    end
  end

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rd_view = wr_view;
`else
    rd_view = pairs_q;
`endif
  end

  assign oob_d = oob_q | oob_ra | oob_rb | (we & oob_w) | (idu_en & oob_idu);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pairs_q <= reset_file();
      oob_q   <= 1'b0;
    end else begin
      pairs_q <= pairs_d;
      oob_q   <= oob_d;
    end
  end

  assign rdata_a = read_port(rd_view, rsel_a);
  assign rdata_b = read_port(rd_view, rsel_b);
  assign pc_out  = pairs_q[PC_IDX];
  assign sp_out  = pairs_q[SP_IDX];
  assign oob_err = oob_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver pushes expected values tagged with the cycle they
// apply to; a monitor on the falling edge pops and compares them against the DUT outputs.

module tb_regfile_mp;

  localparam int unsigned IW = 3;

  logic          clock;
  logic          reset;
  logic [IW+1:0] rsel_a, rsel_b, wsel;
  logic [15:0]   rdata_a, rdata_b, wdata, pc_out, sp_out;
  logic          we, idu_en, idu_dec, pc_change, pc_inc, oob_err;
  logic [IW-1:0] idu_idx;

  regfile_mp #(
    .NUM_PAIRS(5),
    .PC_IDX   (4),
    .SP_IDX   (3),
    .RESET_PC (16'h0100),
    .RESET_SP (16'hFFFE),
    .IDX_W    (IW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rsel_a   (rsel_a),
    .rsel_b   (rsel_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata),
    .idu_en   (idu_en),
    .idu_idx  (idu_idx),
    .idu_dec  (idu_dec),
    .pc_change(pc_change),
    .pc_inc   (pc_inc),
    .pc_out   (pc_out),
    .sp_out   (sp_out),
    .oob_err  (oob_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef enum logic [2:0] {SigA, SigB, SigPc, SigSp, SigOob} sig_e;
  typedef struct {
    int          at;
    sig_e        s;
    logic [15:0] v;
    string       n;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  chk_t        c;
  logic [15:0] act;
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      c = q.pop_front();
      unique case (c.s)
        SigA:    act = rdata_a;
        SigB:    act = rdata_b;
        SigPc:   act = pc_out;
        SigSp:   act = sp_out;
        default: act = {15'd0, oob_err};
      endcase
      checks++;
      if (c.at != cyc) begin
        errors++;
        $display("FAIL %s: stale check for cycle %0d seen at cycle %0d", c.n, c.at, cyc);
      end else if (act !== c.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.n, act, c.v);
      end
    end
  end

  task automatic exp(input sig_e s, input logic [15:0] v, input string n);
    chk_t e;
    e.at = cyc;
    e.s  = s;
    e.v  = v;
    e.n  = n;
    q.push_back(e);
  endtask

  // Advance one clock; controls are one-shot.
  task automatic nxt();
    @(posedge clock);
    #1;
    we        = 1'b0;
    idu_en    = 1'b0;
    pc_change = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rsel_a = '0; rsel_b = '0; wsel = '0; wdata = '0;
    we = 1'b0; idu_en = 1'b0; idu_idx = '0; idu_dec = 1'b0;
    pc_change = 1'b0; pc_inc = 1'b0;
    nxt();

    // Reset values
    rsel_a = 5'b10000;
    exp(SigPc,  16'h0100, "reset_pc");
    exp(SigSp,  16'hFFFE, "reset_sp");
    exp(SigA,   16'h0000, "reset_bc");
    exp(SigOob, 16'h0000, "reset_oob");
    reset = 1'b0;
    nxt();

    // Byte writes H then L
    we = 1'b1; wsel = 5'b01010; wdata = 16'h0012;
    nxt();
    we = 1'b1; wsel = 5'b00010; wdata = 16'hAB34;
    nxt();
    rsel_a = 5'b10010; rsel_b = 5'b01010;
    exp(SigA, 16'h1234, "hl_full");
    exp(SigB, 16'h0012, "hl_hi");
    nxt();
    rsel_b = 5'b00010;
    exp(SigB, 16'h0034, "hl_lo");

    // HL wrap on IDU increment alongside PC step
    we = 1'b1; wsel = 5'b10010; wdata = 16'hFFFF;
    nxt();
    idu_en = 1'b1; idu_idx = 3'd2; idu_dec = 1'b0;
    pc_change = 1'b1; pc_inc = 1'b1;
    exp(SigA,  16'hFFFF, "hl_pre_idu");
    exp(SigPc, 16'h0100, "pc_pre_step");
    nxt();
    exp(SigA,  16'h0000, "hl_wrap");
    exp(SigPc, 16'h0101, "pc_step");

    // Write beats IDU on DE
    rsel_a = 5'b10001;
    we = 1'b1; wsel = 5'b10001; wdata = 16'hAAAA;
    idu_en = 1'b1; idu_idx = 3'd1; idu_dec = 1'b1;
    nxt();
    exp(SigA, 16'hAAAA, "de_write_wins");

    // IDU and stepper both on PC: single step
    idu_en = 1'b1; idu_idx = 3'd4; idu_dec = 1'b0;
    pc_change = 1'b1; pc_inc = 1'b1;
    nxt();
    exp(SigPc, 16'h0102, "pc_no_double");

    // Byte write beats IDU: other byte held, no increment
    we = 1'b1; wsel = 5'b00001; wdata = 16'h0055;
    idu_en = 1'b1; idu_idx = 3'd1; idu_dec = 1'b0;
    nxt();
    exp(SigA, 16'hAA55, "de_byte_write_wins");

    // BC underflow on IDU decrement, PC step down
    idu_en = 1'b1; idu_idx = 3'd0; idu_dec = 1'b1;
    pc_change = 1'b1; pc_inc = 1'b0;
    nxt();
    rsel_a = 5'b10000;
    exp(SigA,  16'hFFFF, "bc_underflow");
    exp(SigPc, 16'h0101, "pc_dec");

    // SP increment through IDU
    idu_en = 1'b1; idu_idx = 3'd3; idu_dec = 1'b0;
    nxt();
    exp(SigSp, 16'hFFFF, "sp_inc");

    // Same-cycle read of a written pair
    we = 1'b1; wsel = 5'b10000; wdata = 16'hBEEF;
    exp(SigA, Bypass ? 16'hBEEF : 16'hFFFF, "bc_same_cycle");
    nxt();
    exp(SigA, 16'hBEEF, "bc_after_write");
    we = 1'b1; wsel = 5'b01000; wdata = 16'h0012;
    rsel_b = 5'b10000;
    exp(SigB, Bypass ? 16'h12EF : 16'hBEEF, "bc_byte_same_cycle");
    nxt();
    exp(SigB,   16'h12EF, "bc_byte_after");
    exp(SigOob, 16'h0000, "oob_clear_before");

    // Out-of-range write: no change, sticky flag
    we = 1'b1; wsel = 5'b10111; wdata = 16'h1111;
    nxt();
    rsel_b = 5'b10001;
    exp(SigOob, 16'h0001, "oob_set");
    exp(SigA,   16'h12EF, "oob_bc_kept");
    exp(SigB,   16'hAA55, "oob_de_kept");
    exp(SigPc,  16'h0101, "oob_pc_kept");
    exp(SigSp,  16'hFFFF, "oob_sp_kept");
    nxt();
    rsel_b = 5'b10110;
    exp(SigB,   16'h0000, "oob_read_zero");
    exp(SigOob, 16'h0001, "oob_held");
    nxt();
    rsel_b = 5'b10001;
    exp(SigOob, 16'h0001, "oob_held2");
    nxt();

    // Mid-test asynchronous reset
    reset = 1'b1;
    #1;
    exp(SigOob, 16'h0000, "oob_reset");
    exp(SigPc,  16'h0100, "pc_reset_again");
    exp(SigSp,  16'hFFFE, "sp_reset_again");
    exp(SigA,   16'h0000, "bc_reset_again");
    nxt();
    reset = 1'b0;
    nxt();
    nxt();

    while (q.size() > 0) begin
      c = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: check never performed", c.n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
